// File: rtl/gearbox_param.sv
// gearbox_param: parametrised unit-width gearbox. Packs IN_UNITS units per
// write into a circular unit buffer and presents OUT_UNITS units per word on a
// registered show-ahead output. Flush drains the buffer and emits a zero-padded
// tail word. Sticky overflow/underflow flags report misuse of the interface.
module gearbox_param #(
  parameter int unsigned UNIT_W    = 4,
  parameter int unsigned IN_UNITS  = 4,
  parameter int unsigned OUT_UNITS = 5,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned LVL_W     = $clog2(DEPTH) + 1,
  parameter int unsigned PAD_W     = $clog2(OUT_UNITS + 1)
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          shift_in,
  input  logic [IN_UNITS*UNIT_W-1:0]    data_in,
  output logic                          full,
  input  logic                          flush,
  input  logic                          shift_out,
  output logic                          valid_out,
  output logic [OUT_UNITS*UNIT_W-1:0]   data_out,
  output logic                          last_out,
  output logic [PAD_W-1:0]              pad_units,
  output logic [LVL_W-1:0]              level,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [LVL_W-1:0] LVL_IN   = LVL_W'(IN_UNITS);
  localparam logic [LVL_W-1:0] LVL_OUT  = LVL_W'(OUT_UNITS);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH - IN_UNITS);
  localparam logic [PTR_W-1:0] PTR_IN   = PTR_W'(IN_UNITS);
  localparam logic [PTR_W-1:0] PTR_OUT  = PTR_W'(OUT_UNITS);
  localparam logic [PAD_W-1:0] PAD_OUT  = PAD_W'(OUT_UNITS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [UNIT_W-1:0]           mem [DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        wr_en;
  logic                        load_ok;
  logic                        norm_load;
  logic                        part_load;
  logic [LVL_W-1:0]            level_d;
  logic [OUT_UNITS*UNIT_W-1:0] load_word;

  assign full      = (level > LVL_FULL) || (state_q == FLUSH);
  assign wr_en     = shift_in && !full;
  assign load_ok   = !valid_out || shift_out;
  assign norm_load = load_ok && (level >= LVL_OUT);
  assign part_load = (state_q == FLUSH) && load_ok &&
                     (level != '0) && (level < LVL_OUT);

  // Next-state logic: flush enters FLUSH; leave once the buffer is drained or
  // the padded tail word is loaded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
      FLUSH:   if ((level == '0) || part_load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Unit buffer write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < IN_UNITS; i++) begin
        mem[wr_ptr + PTR_W'(i)] <= data_in[i*UNIT_W +: UNIT_W];
      end
    end
  end

  // Gather the next output word; units at or above level read as zero, which
  // yields the padded tail for a partial load (a normal load has level >= OUT_UNITS).
  always_comb begin
    load_word = '0;
    for (int unsigned i = 0; i < OUT_UNITS; i++) begin
      if (LVL_W'(i) < level) load_word[i*UNIT_W +: UNIT_W] = mem[rd_ptr + PTR_W'(i)];
    end
  end

  // Fill level: writes add IN_UNITS, normal loads remove OUT_UNITS, a partial
  // load empties the buffer (writes are blocked in FLUSH so they never coincide).
  always_comb begin
    level_d = level;
    if (wr_en)          level_d = level_d + LVL_IN;
    if (norm_load)      level_d = level_d - LVL_OUT;
    else if (part_load) level_d = level_d - level;
  end

  // Pointers and level register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_d;
      if (wr_en)          wr_ptr <= wr_ptr + PTR_IN;
      if (norm_load)      rd_ptr <= rd_ptr + PTR_OUT;
      else if (part_load) rd_ptr <= rd_ptr + level[PTR_W-1:0];
    end
  end

  // Registered show-ahead output stage.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
      pad_units <= '0;
    end else if (norm_load) begin
      valid_out <= 1'b1;
      data_out  <= load_word;
      last_out  <= 1'b0;
      pad_units <= '0;
    end else if (part_load) begin
      valid_out <= 1'b1;
      data_out  <= load_word;
      last_out  <= 1'b1;
      pad_units <= PAD_OUT - PAD_W'(level);
    end else if (shift_out && valid_out) begin
      valid_out <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (shift_in && full)        overflow <= 1'b1;
      else if (clr_err)            overflow <= 1'b0;
      if (shift_out && !valid_out) underflow <= 1'b1;
      else if (clr_err)            underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gearbox_param.sv
// Directed bench for gearbox_param with default geometry (4-bit units,
// 4 in / 5 out, depth 32).
module tb_gearbox_param;

  logic        clk = 1'b0;
  logic        res;
  logic        shift_in;
  logic [15:0] data_in;
  logic        full;
  logic        flush;
  logic        shift_out;
  logic        valid_out;
  logic [19:0] data_out;
  logic        last_out;
  logic [2:0]  pad_units;
  logic [5:0]  level;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  int n_chk  = 0;
  int n_pass = 0;

  gearbox_param #(
    .UNIT_W(4), .IN_UNITS(4), .OUT_UNITS(5), .DEPTH(32), .LVL_W(6), .PAD_W(3)
  ) dut (
    .clk(clk), .res(res), .shift_in(shift_in), .data_in(data_in), .full(full),
    .flush(flush), .shift_out(shift_out), .valid_out(valid_out),
    .data_out(data_out), .last_out(last_out), .pad_units(pad_units),
    .level(level), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        si;
    logic [15:0] din;
    logic        fl;
    logic        so;
    logic        ce;
    logic        chkd;
    logic        vo;
    logic [19:0] dout;
    logic        lo;
    logic [2:0]  pad;
    logic [5:0]  lvl;
    logic        fu;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    shift_in  = 1'b0;
    data_in   = 16'h0;
    flush     = 1'b0;
    shift_out = 1'b0;
    clr_err   = 1'b0;
    res       = 1'b1;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
  endtask

  initial begin
    logic [3:0]  q [$];
    logic [19:0] expw;
    logic [15:0] dw;
    int          words, errs;
    logic [5:0]  maxl;

    //            si   din        fl    so    ce    chkd  vo    dout       lo    pad   lvl    fu    ov    un
    vecs[0] = '{1'b1, 16'h3210, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 3'd0, 6'd4, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h7654, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 3'd0, 6'd8, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h43210, 1'b0, 3'd0, 6'd3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'h43210, 1'b0, 3'd0, 6'd3, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h00765, 1'b1, 3'd2, 6'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    do_reset();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data",  32'(data_out),  32'd0);
    chk("rst_last",  32'(last_out),  32'd0);
    chk("rst_pad",   32'(pad_units), 32'd0);
    chk("rst_level", 32'(level),     32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    chk("rst_unf",   32'(underflow), 32'd0);

    // Table: first word, flush tail, underflow set/clear.
    for (int i = 0; i < 8; i++) begin
      shift_in  = vecs[i].si;
      data_in   = vecs[i].din;
      flush     = vecs[i].fl;
      shift_out = vecs[i].so;
      clr_err   = vecs[i].ce;
      step();
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].vo));
      chk($sformatf("v%0d_level", i), 32'(level),     32'(vecs[i].lvl));
      chk($sformatf("v%0d_full", i),  32'(full),      32'(vecs[i].fu));
      chk($sformatf("v%0d_ovf", i),   32'(overflow),  32'(vecs[i].ov));
      chk($sformatf("v%0d_unf", i),   32'(underflow), 32'(vecs[i].un));
      if (vecs[i].chkd) begin
        chk($sformatf("v%0d_data", i), 32'(data_out),  32'(vecs[i].dout));
        chk($sformatf("v%0d_last", i), 32'(last_out),  32'(vecs[i].lo));
        chk($sformatf("v%0d_pad", i),  32'(pad_units), 32'(vecs[i].pad));
      end
    end

    // Full boundary: 9 writes fit (one word moves to the output register).
    do_reset();
    shift_in = 1'b1;
    data_in  = 16'h1111;
    repeat (9) step();
    chk("full_level31", 32'(level),     32'd31);
    chk("full_flag",    32'(full),      32'd1);
    chk("full_ovf0",    32'(overflow),  32'd0);
    chk("full_valid",   32'(valid_out), 32'd1);
    step();
    chk("full_drop_level", 32'(level),    32'd31);
    chk("full_ovf1",       32'(overflow), 32'd1);
    clr_err = 1'b1;
    step();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    shift_in = 1'b0;
    step();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    clr_err = 1'b0;

    // Wrap-around stream with continuous reads.
    do_reset();
    words = 0;
    errs  = 0;
    maxl  = '0;
    for (int c = 0; c < 260; c++) begin
      if (c < 200) begin
        shift_in = 1'b1;
        data_in  = 16'(c);
      end else begin
        shift_in = 1'b0;
      end
      shift_out = 1'b1;
      if (valid_out) begin
        if (q.size() < 5) begin
          errs++;
        end else begin
          for (int u = 0; u < 5; u++) expw[u*4 +: 4] = q.pop_front();
          if (data_out !== expw) errs++;
          words++;
        end
      end
      if (shift_in && !full) begin
        dw = data_in;
        for (int u = 0; u < 4; u++) q.push_back(dw[u*4 +: 4]);
      end
      step();
      if (level > maxl) maxl = level;
      if (c >= 200 && q.size() == 0 && !valid_out) break;
    end
    shift_out = 1'b0;
    chk("wrap_words",      32'(words),    32'd160);
    chk("wrap_errs",       32'(errs),     32'd0);
    chk("wrap_drained",    32'(q.size()), 32'd0);
    chk("wrap_maxlvl_gt28", 32'(maxl > 6'd28), 32'd0);
    chk("wrap_ovf",        32'(overflow), 32'd0);

    // Underflow, then simultaneous write and read.
    do_reset();
    shift_out = 1'b1;
    step();
    chk("unf_set", 32'(underflow), 32'd1);
    shift_out = 1'b0;
    clr_err   = 1'b1;
    step();
    clr_err = 1'b0;
    chk("unf_clr", 32'(underflow), 32'd0);
    shift_in = 1'b1;
    data_in  = 16'hBEEF;
    repeat (3) step();
    chk("sim_pre_level", 32'(level),     32'd7);
    chk("sim_pre_valid", 32'(valid_out), 32'd1);
    shift_out = 1'b1;
    step();
    chk("sim_level6", 32'(level), 32'd6);
    step();
    chk("sim_level5", 32'(level), 32'd5);
    step();
    chk("sim_level4", 32'(level), 32'd4);
    step();
    chk("sim_level8",  32'(level),     32'd8);
    chk("sim_valid0",  32'(valid_out), 32'd0);
    shift_in  = 1'b0;
    shift_out = 1'b0;

    // Reset in the middle of a flush.
    do_reset();
    shift_in = 1'b1;
    data_in  = 16'h3210;
    step();
    data_in = 16'h7654;
    step();
    shift_in = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("mf_in_flush", 32'(full),  32'd1);
    chk("mf_level3",   32'(level), 32'd3);
    #3 res = 1'b1;
    #1;
    chk("mf_rst_valid", 32'(valid_out), 32'd0);
    chk("mf_rst_data",  32'(data_out),  32'd0);
    chk("mf_rst_level", 32'(level),     32'd0);
    chk("mf_rst_full",  32'(full),      32'd0);
    chk("mf_rst_last",  32'(last_out),  32'd0);
    @(posedge clk);
    #1 res = 1'b0;
    shift_in = 1'b1;
    data_in  = 16'hABCD;
    flush    = 1'b1;
    step();
    shift_in = 1'b0;
    flush    = 1'b0;
    chk("mf_wr_level", 32'(level), 32'd4);
    chk("mf_wr_full",  32'(full),  32'd1);
    step();
    chk("mf_tail_valid", 32'(valid_out), 32'd1);
    chk("mf_tail_data",  32'(data_out),  32'h0ABCD);
    chk("mf_tail_pad",   32'(pad_units), 32'd1);
    chk("mf_tail_last",  32'(last_out),  32'd1);
    chk("mf_tail_level", 32'(level),     32'd0);
    step();
    chk("mf_idle_full", 32'(full), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
